odd_seq_checker: RTL and testbench
==================================

Name: odd_seq_checker

Overview:
Downstream monitor for the 4-bit odd counter. It samples the counter's count stream and checks that it follows the legal odd sequence 1,3,5,…,15,1. It reports lock status, error events and a wrap tally for debug and scoreboarding. It is synthesizable and sits beside the counter in the top-level, so the bench can drive it with either the real counter or a stimulus model.

Parameters:
WIDTH, 4, width of count_in; largest legal odd value MAX_ODD = 2^WIDTH-1
LOCK_LEN, 3, consecutive legal transitions required to declare lock (1..15)
CNT_W, 8, width of err_count and wrap_count

Ports:
clk  in  1  rising-edge clock, shared with the counter
reset  in  1  asynchronous, active-low (asserted at 0), clears all state immediately
count_in  in  WIDTH  value produced by the upstream odd counter
count_valid  in  1  sample enable; count_in is ignored when 0
locked  out  1  sequence tracked correctly for at least LOCK_LEN transitions
err_pulse  out  1  one-cycle flag for an illegal sample
err_value  out  WIDTH  last offending count_in value
err_count  out  CNT_W  total errors, saturating at all-ones
wrap_count  out  CNT_W  number of MAX_ODD→1 transitions while locked, modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async) forces the following, and holds them while reset=0:
  - state=IDLE, locked=0, err_pulse=0, err_value=0, err_count=0, wrap_count=0
  - prev register=0, lock counter=0
- All outputs are registered. The effect of a sample accepted at edge N is visible after edge N (1-cycle latency). err_pulse is high for exactly one cycle.
- Expected next value: exp = (prev==MAX_ODD) ? 1 : prev+2, computed at WIDTH+1 bits with no silent wrap.
- Sample classes, evaluated only when count_valid=1:
  - ZERO: count_in==0, meaning the upstream counter was reset.
  - LEGAL: count_in==exp.
  - HOLD: count_in==prev and odd.
  - BAD: any other value, including an even nonzero value or a skipped odd value.
- FSM states: IDLE, ACQUIRE, LOCKED, ERROR.
  - IDLE:
    - odd sample → prev=count_in, lockcnt=0, go to ACQUIRE
    - ZERO → stay in IDLE
    - even nonzero → BAD
  - ACQUIRE:
    - LEGAL → prev=count_in, lockcnt++; when lockcnt reaches LOCK_LEN, go to LOCKED and set locked=1 on that edge
    - HOLD → no change
    - ZERO → IDLE, no error
    - BAD → ERROR
  - LOCKED:
    - LEGAL → prev=count_in; if prev was MAX_ODD, wrap_count++
    - HOLD → no change
    - ZERO → IDLE, locked=0, no error (a legitimate upstream reset)
    - BAD → ERROR, locked=0
  - ERROR: entered with err_pulse=1, err_value=count_in, err_count += 1 unless already saturated. Stays exactly one cycle, then goes unconditionally to IDLE with prev=0. A sample offered during the ERROR cycle is ignored.
- count_valid=0 in any state: no state change and no error; err_pulse returns to 0.
- Wrap counting occurs only in LOCKED; a 15→1 transition in ACQUIRE counts toward lock but does not increment wrap_count.
- Simultaneous events: a ZERO sample takes priority over BAD classification.
- Reset mid-operation: reset asserted at any time returns every output to its reset value asynchronously. A reset asserted during an err_pulse cycle truncates the pulse.
- err_count saturates and stays at 2^CNT_W-1. wrap_count rolls over to 0.

Decomposition:
- Shared package (or include file): state encodings (IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2, ERROR=2'd3) and the sample-class encodings.
- One sub-module, odd_seq_classify: combinational; takes prev and count_in and produces exp and the class (ZERO/LEGAL/HOLD/BAD).
- The FSM, counters and output registers stay in odd_seq_checker.

Test Plan:
- Reset then stream 1,3,5,7 with valid=1 every cycle → locked=1 after the edge sampling 7 (LOCK_LEN=3), err_count=0.
- Locked stream 13,15,1,3 → wrap_count 0→1 after the edge sampling 1, locked stays 1, err_pulse never asserts.
- Locked at 5, inject 9 → err_pulse=1 for one cycle, err_value=9, err_count=1, locked=0; then 11,13,15,1 re-locks.
- Locked at 5, upstream reset drives 0 then 1,3,5,7 → no err_pulse, locked drops after 0 and re-asserts after 7.
- Inject 300 BAD samples (alternating 2 and 4) → err_count saturates at 255 and does not wrap.
- Assert reset=0 mid-stream while locked with wrap_count=2 → all outputs read 0 before the next clock edge; count_valid=0 cycles never change state.

Source files
------------

// File: rtl/odd_seq_checker_pkg.sv
// Shared encodings for the odd-sequence monitor: FSM states and sample classes.
package odd_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO  = 2'd0,
        CLS_LEGAL = 2'd1,
        CLS_HOLD  = 2'd2,
        CLS_BAD   = 2'd3
    } sample_cls_t;

endpackage

// File: rtl/odd_seq_checker_classify.sv
// Combinational classifier: predicts the next odd value from prev and sorts
// the incoming sample into ZERO / LEGAL / HOLD / BAD.
module odd_seq_classify
    import odd_seq_checker_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH:0]   exp_val,
    output sample_cls_t      cls
);

    localparam logic [WIDTH-1:0] MAX_ODD = '1;

    always_comb begin
        // One extra bit so prev+2 never aliases back into the legal range.
        if (prev == MAX_ODD) begin
            exp_val = (WIDTH+1)'(1);
        end else begin
            exp_val = {1'b0, prev} + (WIDTH+1)'(2);
        end

        if (count_in == '0) begin
            cls = CLS_ZERO;
        end else if ({1'b0, count_in} == exp_val) begin
            cls = CLS_LEGAL;
        end else if ((count_in == prev) && count_in[0]) begin
            cls = CLS_HOLD;
        end else begin
            cls = CLS_BAD;
        end
    end

endmodule

// File: rtl/odd_seq_checker.sv
// Monitor for the odd counter stream 1,3,...,MAX_ODD,1: lock tracking,
// error capture with a saturating tally, and a wrap tally while locked.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no reference value; waiting for first odd sample
//   ST_ACQUIRE | tracking, counting legal steps toward LOCK_LEN
//   ST_LOCKED  | sequence confirmed; wraps are tallied
//   ST_ERROR   | one-cycle error slot, then back to ST_IDLE
module odd_seq_checker
    import odd_seq_checker_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [WIDTH-1:0] err_value,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    localparam int LCNT_W = 4;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0]   err_value_q, err_value_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   wrap_count_q, wrap_count_d;

    logic [WIDTH:0]     exp_val;
    sample_cls_t        cls;
    logic               raise_err;

    odd_seq_classify #(.WIDTH(WIDTH)) u_classify (
        .prev     (prev_q),
        .count_in (count_in),
        .exp_val  (exp_val),
        .cls      (cls)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        lock_cnt_d   = lock_cnt_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        err_value_d  = err_value_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        raise_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No reference yet, so any odd value seeds the tracker.
                if (count_valid && (count_in != '0)) begin
                    if (count_in[0]) begin
                        prev_d     = count_in;
                        lock_cnt_d = '0;
                        state_d    = ST_ACQUIRE;
                    end else begin
                        raise_err = 1'b1;
                    end
                end
            end
            ST_ACQUIRE: begin
                if (count_valid) begin
                    case (cls)
                        CLS_ZERO: begin
                            state_d = ST_IDLE;
                            prev_d  = '0;
                        end
                        CLS_LEGAL: begin
                            prev_d     = count_in;
                            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                            if (lock_cnt_d == LCNT_W'(LOCK_LEN)) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                        CLS_HOLD: ;
                        default: raise_err = 1'b1;
                    endcase
                end
            end
            ST_LOCKED: begin
                if (count_valid) begin
                    case (cls)
                        CLS_ZERO: begin
                            state_d  = ST_IDLE;
                            locked_d = 1'b0;
                            prev_d   = '0;
                        end
                        CLS_LEGAL: begin
                            prev_d = count_in;
                            if (exp_val == (WIDTH+1)'(1)) begin
                                wrap_count_d = wrap_count_q + CNT_W'(1);
                            end
                        end
                        CLS_HOLD: ;
                        default: raise_err = 1'b1;
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
                prev_d  = '0;
            end
        endcase

        if (raise_err) begin
            state_d     = ST_ERROR;
            locked_d    = 1'b0;
            lock_cnt_d  = '0;
            err_pulse_d = 1'b1;
            err_value_d = count_in;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            lock_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_value_q  <= '0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            lock_cnt_q   <= lock_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_value_q  <= err_value_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_value  = err_value_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker: lock, wrap, error, upstream reset,
// saturation and asynchronous reset, with hand-computed expectations.
module tb_odd_seq_checker;

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;
    logic       locked;
    logic       err_pulse;
    logic [3:0] err_value;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int n_checks = 0;
    int n_err    = 0;

    odd_seq_checker #(.WIDTH(4), .LOCK_LEN(3), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_value   (err_value),
        .err_count   (err_count),
        .wrap_count  (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic vld);
        count_in    = v;
        count_valid = vld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        count_in    = '0;
        count_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_locked",     32'(locked),     0);
        chk("rst_err_pulse",  32'(err_pulse),  0);
        chk("rst_err_value",  32'(err_value),  0);
        chk("rst_err_count",  32'(err_count),  0);
        chk("rst_wrap_count", 32'(wrap_count), 0);
        reset = 1'b1;
        step(4'd0, 1'b0);

        // Acquire: 1 seeds, 3/5/7 are three legal steps.
        step(4'd1, 1'b1);
        step(4'd3, 1'b1);
        step(4'd5, 1'b1);
        chk("acq_not_yet", 32'(locked), 0);
        step(4'd7, 1'b1);
        chk("acq_locked",    32'(locked),    1);
        chk("acq_err_count", 32'(err_count), 0);

        // Locked run through the wrap.
        step(4'd9,  1'b1);
        step(4'd11, 1'b1);
        step(4'd13, 1'b1);
        chk("run_pulse13", 32'(err_pulse), 0);
        step(4'd15, 1'b1);
        chk("wrap_before", 32'(wrap_count), 0);
        chk("run_pulse15", 32'(err_pulse),  0);
        step(4'd1, 1'b1);
        chk("wrap_after",  32'(wrap_count), 1);
        chk("run_pulse1",  32'(err_pulse),  0);
        step(4'd3, 1'b1);
        chk("run_locked3", 32'(locked),    1);
        chk("run_pulse3",  32'(err_pulse), 0);

        // Locked at 5, skip to 9.
        step(4'd5, 1'b1);
        step(4'd9, 1'b1);
        chk("bad_pulse",     32'(err_pulse), 1);
        chk("bad_value",     32'(err_value), 9);
        chk("bad_err_count", 32'(err_count), 1);
        chk("bad_locked",    32'(locked),    0);
        step(4'd0, 1'b0);
        chk("bad_pulse_end", 32'(err_pulse), 0);
        step(4'd11, 1'b1);
        step(4'd13, 1'b1);
        step(4'd15, 1'b1);
        chk("relock_not_yet", 32'(locked), 0);
        step(4'd1, 1'b1);
        chk("relock",          32'(locked),     1);
        chk("acq_wrap_no_inc", 32'(wrap_count), 1);

        // Upstream reset while locked at 5.
        step(4'd3, 1'b1);
        step(4'd5, 1'b1);
        step(4'd0, 1'b1);
        chk("zero_unlock", 32'(locked),    0);
        chk("zero_no_err", 32'(err_pulse), 0);
        step(4'd1, 1'b1);
        step(4'd3, 1'b1);
        step(4'd5, 1'b1);
        chk("zero_reacq", 32'(locked), 0);
        step(4'd7, 1'b1);
        chk("zero_relock",     32'(locked),    1);
        chk("zero_err_count",  32'(err_count), 1);

        // Invalid cycles carry junk that must be ignored; then hold.
        step(4'd2, 1'b0);
        step(4'd2, 1'b0);
        step(4'd6, 1'b0);
        chk("nv_locked",    32'(locked),    1);
        chk("nv_pulse",     32'(err_pulse), 0);
        chk("nv_err_count", 32'(err_count), 1);
        step(4'd9, 1'b1);
        step(4'd9, 1'b1);
        chk("hold_locked", 32'(locked),    1);
        chk("hold_pulse",  32'(err_pulse), 0);
        step(4'd11, 1'b1);
        step(4'd13, 1'b1);
        step(4'd15, 1'b1);
        step(4'd1,  1'b1);
        chk("wrap_two", 32'(wrap_count), 2);

        // Asynchronous reset between edges.
        count_in    = 4'd3;
        count_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_locked",     32'(locked),     0);
        chk("async_wrap_count", 32'(wrap_count), 0);
        chk("async_err_count",  32'(err_count),  0);
        chk("async_err_value",  32'(err_value),  0);
        chk("async_pulse",      32'(err_pulse),  0);
        step(4'd3, 1'b1);
        chk("async_hold_locked", 32'(locked), 0);
        reset = 1'b1;

        // Errors from IDLE take two cycles each (error slot ignores sample).
        for (int i = 0; i < 600; i++) begin
            step((i % 2 == 0) ? 4'd2 : 4'd4, 1'b1);
            if (i == 0) begin
                chk("sat_first_pulse", 32'(err_pulse), 1);
                chk("sat_first_value", 32'(err_value), 2);
                chk("sat_first_count", 32'(err_count), 1);
            end else if (i == 1) begin
                chk("sat_ignored_pulse", 32'(err_pulse), 0);
                chk("sat_ignored_value", 32'(err_value), 2);
                chk("sat_ignored_count", 32'(err_count), 1);
            end else if (i == 19) begin
                chk("sat_count10", 32'(err_count), 10);
            end else if (i == 509) begin
                chk("sat_count255", 32'(err_count), 255);
            end
        end
        chk("sat_no_wrap", 32'(err_count), 255);
        chk("sat_locked",  32'(locked),    0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
